// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: multi-cycle add/subtract engine that processes one 4-bit
// nibble per clock, least-significant nibble first. The carry (or not-borrow)
// is chained between nibbles. Operations start and finish through a
// start/busy/done handshake.
module nibble_serial_alu #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b_eff;   // B already inverted for subtract
  logic [W-1:0]    r_acc;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic            w_load;
  logic            w_last;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_t;
  logic [W-1:0]    w_acc_next;

  // A new operation is accepted from IDLE or straight out of DONE.
  assign w_load = start && (r_state != RUN);
  assign w_last = (r_idx == LAST_IDX);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  // NOTE: next-state gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Select the current nibble pair, add it, and splice the result into the accumulator.
  always_comb begin
    w_a_nib    = '0;
    w_b_nib    = '0;
    w_acc_next = r_acc;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b_eff[4*n +: 4];
      end
    end
    w_t = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_carry};
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IW'(n)) w_acc_next[4*n +: 4] = w_t[3:0];
    end
  end

  // Operand latch, per-nibble datapath, and result registers.
  // NOTE: every register here, including the operand and accumulator
  // storage, is cleared by reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b_eff <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= A;
      r_b_eff <= B ^ {W{sub}};
      r_acc   <= '0;
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_t[4];
      if (!w_last) r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_t[4];
        r_ovf  <= (r_a[W-1] == r_b_eff[W-1]) && (w_acc_next[W-1] != r_a[W-1]);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed testbench for nibble_serial_alu with the default NIBBLES=2.
// Inputs change on the falling edge and outputs are sampled there as well.
module tb_nibble_serial_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  nibble_serial_alu #(.NIBBLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait up to 'budget' falling edges for done; returns 1 if seen.
  // Also counts the sampled cycles in which busy was high before done.
  task automatic wait_done(input int budget, output bit seen, output int busy_cyc);
    seen     = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  // One full operation: single-cycle start, operands scrambled during RUN.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    bit seen;
    int bc;
    @(negedge clk);
    start = 1'b1; A = a; B = b; sub = s;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; sub = ~s;
    wait_done(8, seen, bc);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd2);
    check({tag, "_sum"}, 32'(sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  logic [7:0] v_a   [3] = '{8'h24, 8'h76, 8'h12};
  logic [7:0] v_b   [3] = '{8'h81, 8'h3D, 8'h8F};
  logic       v_s   [3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] v_sum [3] = '{8'hA5, 8'h39, 8'h83};
  logic       v_co  [3] = '{1'b0, 1'b1, 1'b0};
  logic       v_ov  [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    bit seen;
    int bc;
    int last_done;
    int done_cnt;

    rst_n = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single operations.
    run_op("add_nc",  8'h24, 8'h81, 1'b0, 8'hA5, 1'b0, 1'b0);
    run_op("add_cov", 8'hED, 8'h8C, 1'b0, 8'h79, 1'b1, 1'b1);
    run_op("sub_nb",  8'h76, 8'h3D, 1'b1, 8'h39, 1'b1, 1'b0);
    run_op("sub_bov", 8'h12, 8'h8F, 1'b1, 8'h83, 1'b0, 1'b1);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_sum", 32'(sum), 32'h83);

    // Start pulse during RUN is ignored.
    @(negedge clk);
    start = 1'b1; A = 8'h24; B = 8'h81; sub = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; sub = 1'b1;           // start still high, inside RUN
    @(negedge clk);
    start = 1'b0;
    wait_done(8, seen, bc);
    check("ign_done_seen", 32'(seen), 32'd1);
    check("ign_sum", 32'(sum), 32'hA5);
    check("ign_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("ign_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ign_no_extra_done", 32'(done), 32'd0);

    // Back-to-back: start held high, operands advanced after each acceptance.
    @(negedge clk);
    start = 1'b1; A = v_a[0]; B = v_b[0]; sub = v_s[0];
    last_done = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j < 2) begin
        A = v_a[j+1]; B = v_b[j+1]; sub = v_s[j+1];
      end else begin
        start = 1'b0;
      end
      wait_done(8, seen, bc);
      check($sformatf("b2b%0d_done_seen", j), 32'(seen), 32'd1);
      check($sformatf("b2b%0d_sum", j), 32'(sum), 32'(v_sum[j]));
      check($sformatf("b2b%0d_cout", j), 32'(cout), 32'(v_co[j]));
      check($sformatf("b2b%0d_ovf", j), 32'(ovf), 32'(v_ov[j]));
      if (j > 0) check($sformatf("b2b%0d_gap", j), 32'(cyc - last_done), 32'd3);
      last_done = cyc;
    end
    @(negedge clk);
    check("b2b_end_done", 32'(done), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; A = 8'hF9; B = 8'hC6; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                              // first RUN edge
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum",  32'(sum),  32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf",  32'(ovf),  32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_sum_held", 32'(sum), 32'd0);
    run_op("post_rst", 8'hF9, 8'hC6, 1'b0, 8'hBF, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
